// File: rtl/mult_seq_pkg.sv
// Shared constants and types for the multiplier job sequencer.
package mult_seq_pkg;

    localparam int unsigned dp_width   = 5;
    localparam int unsigned fifo_depth = 4;
    localparam int unsigned wait_limit = 64;
    localparam int unsigned st_width   = 2;

    typedef enum logic [st_width-1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } seq_state_t;

    typedef struct packed {
        logic [dp_width-1:0] multiplicand;
        logic [dp_width-1:0] multiplier;
    } operand_pair_t;

endpackage

// File: rtl/mult_seq_fifo.sv
// Synchronous FIFO of operand pairs; head is presented combinationally from storage.
module mult_seq_fifo
    import mult_seq_pkg::*;
#(
    parameter type         T     = operand_pair_t,
    parameter int unsigned DEPTH = fifo_depth
) (
    input  logic clk,
    input  logic rst_b,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    T     mem [DEPTH];
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count;
    logic do_push;
    logic do_pop;

    assign full    = (count == cnt_t'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// In-order job sequencer around the add-shift multiplier (start/rdy protocol).
// Define MULT_SEQ_STATS_EN to add the jobs_done and busy_cycles counters.
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int unsigned DP_WIDTH   = dp_width,
    parameter int unsigned FIFO_DEPTH = fifo_depth,
    parameter int unsigned WAIT_LIMIT = wait_limit
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DP_WIDTH-1:0]   in_multiplicand,
    input  logic [DP_WIDTH-1:0]   in_multiplier,
    output logic                  mul_start,
    output logic [DP_WIDTH-1:0]   mul_multiplicand,
    output logic [DP_WIDTH-1:0]   mul_multiplier,
    input  logic                  mul_rdy,
    input  logic [2*DP_WIDTH-1:0] mul_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DP_WIDTH-1:0] out_product,
`ifdef MULT_SEQ_STATS_EN
    output logic [15:0]           jobs_done,
    output logic [15:0]           busy_cycles,
`endif
    output logic                  err
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT) + 1;

    typedef logic [CW-1:0] wcnt_t;

    typedef struct packed {
        logic [DP_WIDTH-1:0] multiplicand;
        logic [DP_WIDTH-1:0] multiplier;
    } pair_t;

    seq_state_t state;
    wcnt_t      wait_cnt;
    pair_t      wr_pair;
    pair_t      head;
    logic       full;
    logic       empty;
    logic       push;
    logic       launch;
    logic       capture;
    logic       timeout;

    assign wr_pair  = '{multiplicand: in_multiplicand, multiplier: in_multiplier};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // An unconsumed result blocks launch so it can never be overwritten.
    assign launch   = (state == IDLE) && !empty && mul_rdy && (!out_valid || out_ready);
    assign capture  = (state == WAIT_DONE) && mul_rdy;
    assign timeout  = (wait_cnt == wcnt_t'(WAIT_LIMIT - 1));

    mult_seq_fifo #(
        .T     (pair_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push    (push),
        .wr_data (wr_pair),
        .pop     (launch),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            err              <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        mul_multiplicand <= head.multiplicand;
                        mul_multiplier   <= head.multiplier;
                        mul_start        <= 1'b1;
                        state            <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!mul_rdy) begin
                        wait_cnt <= '0;
                        state    <= WAIT_DONE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + wcnt_t'(1);
                    end
                end
                WAIT_DONE: begin
                    if (capture) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        state       <= IDLE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + wcnt_t'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            jobs_done   <= '0;
            busy_cycles <= '0;
        end else begin
            if (capture) jobs_done <= jobs_done + 16'd1;
            if (state != IDLE && busy_cycles != '1) busy_cycles <= busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Randomized bench for mult_job_sequencer with a behavioural add-shift multiplier.
module tb_mult_job_sequencer;

    localparam int DP = 5;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            in_valid;
    logic            in_ready;
    logic [DP-1:0]   in_multiplicand;
    logic [DP-1:0]   in_multiplier;
    logic            mul_start;
    logic [DP-1:0]   mul_multiplicand;
    logic [DP-1:0]   mul_multiplier;
    logic            mul_rdy;
    logic [2*DP-1:0] mul_product;
    logic            out_valid;
    logic            out_ready;
    logic [2*DP-1:0] out_product;
    logic            err;
`ifdef MULT_SEQ_STATS_EN
    logic [15:0]     jobs_done;
    logic [15:0]     busy_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int starts   = 0;
    int results  = 0;

    logic [2*DP-1:0] exp_q[$];

    bit ready_mode  = 1'b0;
    bit ready_fixed = 1'b1;
    bit rnd_ready   = 1'b1;
    bit mul_stuck   = 1'b0;
    int busy_min    = 1;
    int busy_max    = 4;
    int busy_left   = 0;
    logic [2*DP-1:0] op_a;
    logic [2*DP-1:0] op_b;

    assign out_ready = ready_mode ? rnd_ready : ready_fixed;

    always #5 clk = ~clk;

    mult_job_sequencer #(
        .DP_WIDTH   (DP),
        .FIFO_DEPTH (4),
        .WAIT_LIMIT (64)
    ) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_rdy          (mul_rdy),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
`ifdef MULT_SEQ_STATS_EN
        .jobs_done        (jobs_done),
        .busy_cycles      (busy_cycles),
`endif
        .err              (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Multiplier model: accepts start while idle, stays busy a random time, then
    // returns rdy with the product. The product bus is garbage while busy.
    always @(posedge clk) begin
        if (mul_rdy) begin
            if (mul_start && !mul_stuck) begin
                mul_rdy     <= 1'b0;
                busy_left   <= $urandom_range(busy_max, busy_min);
                op_a        <= 10'(mul_multiplicand);
                op_b        <= 10'(mul_multiplier);
                mul_product <= 10'($urandom);
            end
        end else if (busy_left <= 1) begin
            mul_rdy     <= 1'b1;
            mul_product <= op_a * op_b;
        end else begin
            busy_left <= busy_left - 1;
        end
    end

    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(1, 0) == 1);
    end

    // Reference: every accepted pair yields its product, consumed in order.
    always @(negedge clk) begin
        if (rst_b) begin
            if (in_valid && in_ready)
                exp_q.push_back(10'(in_multiplicand) * 10'(in_multiplier));
            if (mul_start) starts++;
            if (out_valid && out_ready) begin
                results++;
                if (exp_q.size() == 0) check("unexpected_result", 32'(out_product), 32'hFFFF_FFFF);
                else check("out_product", 32'(out_product), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        exp_q.delete();
        starts  = 0;
        results = 0;
    endtask

    task automatic push_pair(input logic [DP-1:0] a, input logic [DP-1:0] b);
        bit ok = 1'b0;
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        for (int i = 0; i < 1000 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) check("push_accept", 0, 1);
    endtask

    task automatic wait_results(input string tag, input int target);
        int guard = 0;
        while (results < target && guard < 5000) begin
            tick();
            guard++;
        end
        check(tag, 32'(results), 32'(target));
    endtask

    initial begin
        logic [2*DP-1:0] pairs [1024];
        logic [2*DP-1:0] tmp;
        int              snap;
        int              guard;

        mul_rdy         = 1'b1;
        mul_product     = '0;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        rst_b           = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_err", 32'(err), 0);
        check("rst_out_product", 32'(out_product), 0);
        check("rst_mul_operands", 32'({mul_multiplicand, mul_multiplier}), 0);
        do_reset();

        // Single job.
        push_pair(5'd7, 5'd9);
        in_valid = 1'b0;
        wait_results("single_done", 1);
        check("single_starts", 32'(starts), 1);
        check("single_err", 32'(err), 0);

        // Held result, then fill the FIFO behind it.
        ready_fixed = 1'b0;
        push_pair(5'd2, 5'd3);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 200) begin tick(); guard++; end
        check("bp_valid", 32'(out_valid), 1);
        check("bp_product", 32'(out_product), 6);
        snap = starts;
        push_pair(5'd3, 5'd4);
        push_pair(5'd5, 5'd6);
        push_pair(5'd31, 5'd31);
        push_pair(5'd0, 5'd17);
        in_valid = 1'b0;
        check("fill_in_ready", 32'(in_ready), 0);
        repeat (10) tick();
        check("bp_hold_product", 32'(out_product), 6);
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_no_launch", 32'(starts), 32'(snap));
        ready_fixed = 1'b1;
        wait_results("fill_done", 6);
        check("fill_queue_empty", 32'(exp_q.size()), 0);

        // Timeout: multiplier never leaves rdy.
        mul_stuck = 1'b1;
        snap = starts;
        push_pair(5'd5, 5'd5);
        in_valid = 1'b0;
        guard = 0;
        while (!mul_start && guard < 20) begin tick(); guard++; end
        check("to_start_seen", 32'(mul_start), 1);
        repeat (64) tick();
        check("to_err_before", 32'(err), 0);
        tick();
        check("to_err_set", 32'(err), 1);
        check("to_no_valid", 32'(out_valid), 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (5) tick();
        check("to_err_sticky", 32'(err), 1);
        check("to_single_start", 32'(starts - snap), 1);
        check("to_in_ready", 32'(in_ready), 1);
        mul_stuck = 1'b0;
        do_reset();
        check("to_err_cleared", 32'(err), 0);

        // Reset while a job is in WAIT_DONE with two pairs queued.
        busy_min = 20;
        busy_max = 20;
        push_pair(5'd1, 5'd2);
        push_pair(5'd3, 5'd4);
        push_pair(5'd5, 5'd6);
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_busy", 32'(mul_rdy), 0);
        rst_b = 1'b0;
        tick();
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_in_ready", 32'(in_ready), 1);
        check("mid_mul_start", 32'(mul_start), 0);
        rst_b = 1'b1;
        exp_q.delete();
        starts  = 0;
        results = 0;
        repeat (40) tick();
        check("mid_fifo_empty", 32'(starts), 0);
        check("mid_no_result", 32'(out_valid), 0);
        busy_min = 1;
        busy_max = 4;

        // Exhaustive operand sweep in random order with random backpressure.
        do_reset();
        for (int i = 0; i < 1024; i++) pairs[i] = 10'(i);
        for (int i = 1023; i > 0; i--) begin
            int j;
            j        = $urandom_range(i, 0);
            tmp      = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end
        ready_mode = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            tmp = pairs[k];
            if ($urandom_range(3, 0) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(2, 1)) tick();
            end
            push_pair(tmp[9:5], tmp[4:0]);
        end
        in_valid = 1'b0;
        wait_results("sweep_done", 1024);
        check("sweep_queue_empty", 32'(exp_q.size()), 0);
        check("sweep_err", 32'(err), 0);
`ifdef MULT_SEQ_STATS_EN
        check("sweep_jobs_done", 32'(jobs_done), 1024);
`endif
        ready_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
Upstream/downstream wrapper stage for the add-shift binary multiplier. It buffers operand pairs arriving on a valid/ready interface and issues one job at a time to the multiplier using its start/rdy protocol. It captures each finished product into an output register presented on a valid/ready interface. Jobs are strictly in order, with one multiplication in flight at a time.

Parameters:
DP_WIDTH, 5, operand width; must match the multiplier datapath width.
FIFO_DEPTH, 4, operand-pair FIFO entries; power of two, at least 2.
WAIT_LIMIT, 64, maximum cycles in WAIT_BUSY or WAIT_DONE before the error flag is raised.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_b  in  1  synchronous active-low reset.
in_valid  in  1  operand pair offered.
in_ready  out  1  FIFO not full.
in_multiplicand  in  DP_WIDTH  operand A.
in_multiplier  in  DP_WIDTH  operand B.
mul_start  out  1  one-cycle launch pulse to the multiplier.
mul_multiplicand  out  DP_WIDTH  registered operand; held stable from launch until capture.
mul_multiplier  out  DP_WIDTH  registered operand; held stable from launch until capture.
mul_rdy  in  1  multiplier idle/done; high when idle, low while busy.
mul_product  in  2*DP_WIDTH  multiplier result; valid while mul_rdy is high after a job.
out_valid  out  1  result register full.
out_ready  in  1  consumer accepts the result.
out_product  out  2*DP_WIDTH  captured product.
err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_b, sampled at posedge clk.
- Reset values: state=IDLE, FIFO empty, in_ready=1, mul_start=0, mul operand registers=0, out_valid=0, out_product=0, err=0.
- Reset asserted mid-job: everything returns to reset values on that edge. Any in-flight job and all queued pairs are discarded. The multiplier is not informed.
- FIFO:
  - Push on in_valid&&in_ready.
  - Pop on the LAUNCH transition.
  - A push and pop in the same cycle while full is not allowed, because in_ready depends only on the registered count.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- IDLE -> LAUNCH when the FIFO is non-empty, mul_rdy=1, and (out_valid=0 or out_ready=1).
  - In that transition cycle, the head entry is popped into the mul operand registers.
- LAUNCH: mul_start=1 for exactly this one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for mul_rdy=0 (multiplier has accepted the job), then go to WAIT_DONE.
- WAIT_DONE: wait for mul_rdy=1.
  - On that edge, out_product<=mul_product, out_valid<=1, go to IDLE.
  - Latency: the product is registered the cycle after mul_rdy rises.
- Output handshake: out_valid clears on out_valid&&out_ready unless a new capture occurs on the same edge; a new capture wins and out_valid stays 1.
  - No launch is made while out_valid=1 && out_ready=0, so an unconsumed result is never overwritten.
- Simultaneous push and launch with the FIFO empty: not allowed; a pushed pair is launchable from the next cycle (no FIFO bypass).
- Timeout: a cycle counter resets on entry to WAIT_BUSY and on entry to WAIT_DONE.
  - If the counter reaches WAIT_LIMIT, set err=1, drop the job (no capture), and return to IDLE.
- Width: product is 2*DP_WIDTH bits. No truncation or sign handling; operands are unsigned.

Optional Feature:
MULT_SEQ_STATS_EN.
- Defined: adds output jobs_done (16 bits, +1 per capture, wraps at 0xFFFF->0) and output busy_cycles (16 bits, +1 per cycle in LAUNCH/WAIT_BUSY/WAIT_DONE, saturates at 0xFFFF). Both reset to 0.
- Undefined: neither port nor the counters exist. Behaviour is otherwise identical.

Decomposition:
- Package mult_seq_pkg:
  - constants dp_width=5, fifo_depth=4, wait_limit=64;
  - typedef enum seq_state_t {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}; st_width=2;
  - typedef operand_pair_t (packed struct of multiplicand and multiplier).
- Sub-module: mult_seq_fifo, a parameterised sync FIFO of operand_pair_t with push/pop/full/empty/count.
- Top level: FSM, timeout counter, result register, and stats.

Test Plan:
- Single job: push (7,9) with out_ready=1 and a real multiplier attached -> exactly one mul_start pulse; out_valid rises with out_product=63; err=0.
- Back-to-back fill: push (3,4),(5,6),(31,31),(0,17) with no gaps -> in_ready falls after the 4th push; results appear in order 12, 30, 961, 0.
- Backpressure: hold out_ready=0 after the first result of (2,3),(4,5) -> out_product stays 6 and mul_start does not pulse; releasing out_ready -> next result is 20.
- Timeout: stub mul_rdy stuck at 1 after mul_start -> err=1 after 64 cycles in WAIT_BUSY; no out_valid; state returns to IDLE.
- Reset mid-job: assert rst_b=0 during WAIT_DONE with 2 entries queued -> next edge: out_valid=0, in_ready=1, FIFO empty, mul_start=0.
- Exhaustive sweep: all 32x32 operand pairs pushed randomly with out_ready toggling -> every out_product equals multiplicand*multiplier in order; with MULT_SEQ_STATS_EN defined, jobs_done=1024 at the end.
